// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. A word-aligned fetch PC addresses a
// combinational instruction memory. Each fetched {pc, instr} pair is queued in
// a two-entry FIFO whose head is offered to decode. Redirects reload the PC and
// flush the queue.
//
// Handshake: the head is transferred on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready. Once out_valid
// is 1, the head values are held stable until the transfer happens, unless a
// redirect or reset flushes the queue.
//
// Ports
//   clk            : clock, rising-edge
//   rst_n          : asynchronous active-low reset
//   imem_addr      : word index into instruction memory (zero-extended)
//   imem_rd        : instruction word for imem_addr, same cycle
//   redirect_valid : branch/jump redirect request
//   redirect_pc    : redirect byte-address target (low two bits ignored)
//   out_valid      : FIFO head valid
//   out_ready      : decode accepts head this cycle
//   out_instr      : head instruction word
//   out_pc         : head instruction byte address
//   out_pc_plus4   : out_pc + 4 (wraps)
//   dbg_state      : FIFO occupancy state (0 empty, 1 one, 2 full)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 8,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_RESET = {RESET_PC[XLEN-1:2], 2'b00};

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Entry 0 is always the head; entry 1 is only meaningful in ST_FULL.
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [31:0]     head_instr_q, head_instr_d;
    logic [XLEN-1:0] tail_pc_q, tail_pc_d;
    logic [31:0]     tail_instr_q, tail_instr_d;

    logic push;
    logic pop;

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push)          state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)        state_d = ST_FULL;
                    else if (pop && !push)   state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop && !push)  state_d = ST_ONE;
                default:                     state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        pop       = out_valid && out_ready;
        // When full, a fetch is only possible if the head leaves this cycle.
        push      = !redirect_valid && ((state_q != ST_FULL) || pop);
    end

    // ----------------------------------------------------------- datapath ---
    always_comb begin
        pc_d         = pc_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end

        if (push) begin
            // The new entry lands in the head slot if the head is empty or
            // leaving with no older entry behind it; otherwise it goes to the
            // tail, and a full FIFO shifts its tail forward.
            case (state_q)
                ST_EMPTY: begin
                    head_pc_d    = pc_q;
                    head_instr_d = imem_rd;
                end
                ST_ONE: begin
                    if (pop) begin
                        head_pc_d    = pc_q;
                        head_instr_d = imem_rd;
                    end else begin
                        tail_pc_d    = pc_q;
                        tail_instr_d = imem_rd;
                    end
                end
                default: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    tail_pc_d    = pc_q;
                    tail_instr_d = imem_rd;
                end
            endcase
        end else if (pop && (state_q == ST_FULL)) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= PC_RESET;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    // ------------------------------------------------------------ outputs ---
    assign imem_addr    = {{(XLEN-ADDR_WIDTH){1'b0}}, pc_q[ADDR_WIDTH+1:2]};
    assign out_pc       = head_pc_q;
    assign out_instr    = head_instr_q;
    assign out_pc_plus4 = head_pc_q + PC_STEP;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit with default parameters. The instruction memory
// returns 32'h1000_0000 + word index. Inputs change on the falling edge.
// Outputs are sampled 1 ns later, and each record's expectations describe the
// state before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    fetch_unit #(
        .XLEN       (32),
        .ADDR_WIDTH (8),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .dbg_state      (dbg_state)
    );

    // ---------------------------------------------------- clock / memory ---
    always #5 clk = ~clk;

    assign imem_rd = 32'h1000_0000 + imem_addr;

    // ------------------------------------------------------------ helpers ---
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h1000_0000 + {24'h0, pc[9:2]};
    endfunction

    // Check the head entry, including the derived instruction and pc+4.
    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, " valid"}, {31'h0, out_valid}, 32'd1);
        chk({tag, " out_pc"}, out_pc, pc);
        chk({tag, " out_instr"}, out_instr, instr_of(pc));
        chk({tag, " out_pc_plus4"}, out_pc_plus4, pc + 32'd4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("reset valid", {31'h0, out_valid}, 32'd0);
        chk("reset imem_addr", imem_addr, 32'd0);
        chk("reset state", {30'h0, dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------- vectors ---
    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int accepts;
        bit seen;

        // Stall for five cycles, drain, then redirect while full, then
        // issue three back-to-back redirects.
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h00, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h01, 2'd1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h02, 2'd2};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h02, 2'd2};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h02, 2'd2};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h02, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h03, 2'd2};
        vecs[7]  = '{1'b0, 1'b1, 32'h43, 1'b1, 32'h8,  32'h04, 2'd2};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h11, 2'd1};
        vecs[10] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h44, 32'h12, 2'd1};
        vecs[11] = '{1'b1, 1'b1, 32'h20, 1'b0, 32'h0,  32'h04, 2'd0};
        vecs[12] = '{1'b1, 1'b1, 32'h30, 1'b0, 32'h0,  32'h08, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0C, 2'd0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h30, 32'h0D, 2'd1};
        vecs[15] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h34, 32'h0E, 2'd1};

        // ---- free-running stream from reset
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            #1;
            if (n == 0) chk("stream first valid", {31'h0, out_valid}, 32'd0);
            else        chk_head("stream", 32'(4 * (n - 1)));
            @(negedge clk);
        end

        // ---- table-driven stall / redirect sequence
        do_reset();
        for (int i = 0; i < 16; i++) begin
            out_ready      = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk($sformatf("vec%0d valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d state", i), {30'h0, dbg_state}, {30'h0, vecs[i].exp_state});
            if (vecs[i].exp_valid) chk_head($sformatf("vec%0d", i), vecs[i].exp_pc);
            @(negedge clk);
        end
        redirect_valid = 1'b0;

        // ---- asynchronous reset while full at pc 0x24
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre-rst state", {30'h0, dbg_state}, 32'd2);
        chk("pre-rst imem_addr", imem_addr, 32'h9);
        chk_head("pre-rst", 32'h1C);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst valid", {31'h0, out_valid}, 32'd0);
        chk("async rst imem_addr", imem_addr, 32'd0);
        chk("async rst state", {30'h0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 chk("post-rst valid", {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        #1 chk_head("post-rst 0", 32'h0);
        @(negedge clk);
        #1 chk_head("post-rst 1", 32'h4);

        // ---- PC wrap at the top of the address space
        do_reset();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("wrap valid0", {31'h0, out_valid}, 32'd0);
        chk("wrap imem_addr", imem_addr, 32'hFE);
        @(negedge clk);
        #1 chk_head("wrap a", 32'hFFFF_FFF8);
        @(negedge clk);
        #1 chk_head("wrap b", 32'hFFFF_FFFC);
        @(negedge clk);
        #1 chk_head("wrap c", 32'h0);

        // ---- random ready/redirect with a scoreboard of the next expected PC
        do_reset();
        exp_q.delete();
        exp_q.push_back(32'h0);
        accepts = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            #1;
            if (out_valid && out_ready) begin
                accepts++;
                chk("rand out_pc", out_pc, exp_q[0]);
                chk("rand out_instr", out_instr, instr_of(exp_q[0]));
                chk("rand out_pc_plus4", out_pc_plus4, exp_q[0] + 32'd4);
                exp_q.push_back(exp_q[0] + 32'd4);
                void'(exp_q.pop_front());
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back({redirect_pc[31:2], 2'b00});
            end
            @(negedge clk);
        end
        chk("rand enough accepts", {31'h0, accepts > 100}, 32'd1);

        // Liveness: with decode ready the queue must become valid quickly.
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            #1;
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("liveness valid", {31'h0, seen}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter ADDR_WIDTH, default 8, instruction memory word-index width (256 words).
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 imem_addr  output  XLEN  word index driven to instruction memory.
REQ-007 imem_rd  input  32  instruction word returned combinationally, same cycle, for imem_addr.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  XLEN  byte-address redirect target.
REQ-010 out_valid  output  1  head of instruction queue valid.
REQ-011 out_ready  input  1  decode accepts head this cycle.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  XLEN  head instruction byte address.
REQ-014 out_pc_plus4  output  XLEN  out_pc + 4, modulo 2^XLEN.

Function
REQ-015 The block SHALL hold a byte-address fetch PC register pc, always word-aligned (pc[1:0] == 0).
REQ-016 imem_addr SHALL equal zero-extended pc[ADDR_WIDTH+1:2], combinationally from pc.
REQ-017 The block SHALL contain a 2-entry FIFO of {pc, instr} pairs with occupancy states EMPTY (0), ONE (1), FULL (2).
REQ-018 pop = out_valid && out_ready; out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-019 out_instr, out_pc and out_pc_plus4 SHALL reflect the FIFO head; their values when out_valid is 0 are don't-care.
REQ-020 push SHALL be asserted when redirect_valid is 0 and the state is not FULL, or is FULL with pop in the same cycle.
REQ-021 On push, the entry {pc, imem_rd} SHALL be written at the tail and pc SHALL advance by 4 (wrap modulo 2^XLEN); with no push, pc SHALL hold.
REQ-022 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop without push; push and pop together SHALL leave the state unchanged.
REQ-023 FIFO order SHALL be strict: instructions leave in fetch order with no duplication or loss.
REQ-024 A push into EMPTY SHALL make out_valid 1 on the next cycle (1-cycle fetch-to-decode latency); no same-cycle bypass.
REQ-025 On redirect_valid: next state EMPTY, pc loaded with {redirect_pc[XLEN-1:2], 2'b00}, no push; a same-cycle pop is still counted as a handshake, then the FIFO is flushed.
REQ-026 Back-to-back redirects SHALL each take effect; the last one wins, and fetch resumes the cycle after redirect_valid deasserts.
REQ-027 Head entry values SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-028 pc wrap from 32'hFFFF_FFFC SHALL yield 0; imem_addr wraps within ADDR_WIDTH bits.

Reset
REQ-029 While rst_n is 0: pc = RESET_PC, state EMPTY, out_valid = 0, FIFO storage contents don't-care.
REQ-030 Reset SHALL be effective immediately on rst_n falling, including mid-transfer; held entries are discarded.
REQ-031 The first fetch SHALL occur at the first rising edge with rst_n high; imem_addr = RESET_PC[ADDR_WIDTH+1:2] during that cycle.

Verification
REQ-032 Reset release, out_ready=1, imem word n = 32'h1000_0000+n -> out_pc 0,4,8,... one per cycle from cycle 1, out_instr matching, out_pc_plus4 = out_pc+4.
REQ-033 out_ready=0 for 5 cycles after reset -> FULL after 2 cycles, pc holds at 8, head stays pc 0; then out_ready=1 -> pcs 0,4,8 in order, no gap.
REQ-034 Redirect to 32'h0000_0043 while FULL -> next cycle out_valid=0, pc=32'h40; following cycle out_pc=32'h40.
REQ-035 Redirect asserted 3 cycles with targets 0x10, 0x20, 0x30 -> only 0x30 stream appears, nothing from 0x10/0x20.
REQ-036 rst_n pulsed low mid-stream (FULL, pc=0x24) -> out_valid=0 asynchronously; after release the stream restarts at RESET_PC.
REQ-037 Random out_ready/redirect with scoreboard -> every accepted out_pc equals the expected sequential/redirected PC; no loss or duplication.
